// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin scheduler sharing one FIFO write port
// between NUM_REQ requesters. A grant lasts up to MAX_BURST accepted beats,
// stalls (without timing out) while the FIFO is full, and the priority
// pointer moves just past the granted requester on every release.
module fifo_write_arbiter #(
  parameter int FIFO_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_a,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] din_req,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          full,
  output logic                          wen_a,
  output logic [FIFO_WIDTH-1:0]         din_a
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]         state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [PTR_W-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   ptr_after_grant;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               pick_found;
  logic               granted_req;
  logic               beat_accept;
  logic               last_beat;

  logic [FIFO_WIDTH-1:0] masked_din [NUM_REQ];

  // Encode the one-hot grant into an index for pointer rotation.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_reg[i]) grant_idx = PTR_W'(i);
    end
  end

  assign ptr_after_grant = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : PTR_W'(grant_idx + 1'b1);

  // First active requester at or above ptr, wrapping around.
  always_comb begin
    logic [PTR_W-1:0] idx;
    pick_found  = 1'b0;
    pick_onehot = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr_reg) + k) % NUM_REQ);
      if (!pick_found && req[idx]) begin
        pick_found       = 1'b1;
        pick_onehot[idx] = 1'b1;
      end
    end
  end

  // A beat moves only for the granted requester, with room in the FIFO
  // and never during reset.
  assign granted_req = |(grant_reg & req);
  assign beat_accept = granted_req & ~full & ~rst;
  assign last_beat   = (cnt_reg == CNT_W'(MAX_BURST - 1));

  assign wen_a = beat_accept;
  assign ack   = beat_accept ? grant_reg : '0;
  assign grant = grant_reg;

  // Per-requester data gated by its grant bit; OR-combined below so an
  // idle arbiter presents all-zero data.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_din_mask
    assign masked_din[gi] = grant_reg[gi] ? din_req[gi*FIFO_WIDTH +: FIFO_WIDTH] : '0;
  end

  // OR-reduce the masked slices onto the FIFO data bus.
  always_comb begin
    din_a = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      din_a = din_a | masked_din[i];
    end
  end

  // Arbitrate in IDLE, count beats and decide release in BURST.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick_onehot;
          cnt_next   = '0;
          state_next = BURST;
        end
      end
      BURST: begin
        if (!granted_req) begin
          // Requester withdrew: release without writing.
          grant_next = '0;
          ptr_next   = ptr_after_grant;
          state_next = IDLE;
        end else if (!full) begin
          cnt_next = CNT_W'(cnt_reg + 1'b1);
          if (last_beat) begin
            grant_next = '0;
            ptr_next   = ptr_after_grant;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // State registers with synchronous reset; an in-flight burst is dropped.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (defaults: 8-bit, 4 requesters,
// bursts of 4) followed by a randomized invariant run.
module tb_fifo_write_arbiter;

  logic        clk_a = 1'b0;
  logic        rst   = 1'b1;
  logic [3:0]  req   = '0;
  logic [31:0] din_req = '0;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        full  = 1'b0;
  logic        wen_a;
  logic [7:0]  din_a;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit quiet  = 1'b0;

  fifo_write_arbiter #(.FIFO_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk_a   (clk_a),
    .rst     (rst),
    .req     (req),
    .din_req (din_req),
    .ack     (ack),
    .grant   (grant),
    .full    (full),
    .wen_a   (wen_a),
    .din_a   (din_a)
  );

  always #5 clk_a = ~clk_a;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Data that requester g presents in the current cycle.
  function automatic logic [7:0] din_of(input int g);
    return {4'(g), 4'(cyc)};
  endfunction

  // Apply one cycle of inputs after the falling edge, then let outputs settle.
  task automatic run_cycle(input logic [3:0] r, input logic f, input logic rs);
    @(negedge clk_a);
    cyc++;
    req  = r;
    full = f;
    rst  = rs;
    for (int i = 0; i < 4; i++) din_req[i*8 +: 8] = din_of(i);
    #2;
    if (!quiet)
      $display("cyc=%0d req=%b full=%b rst=%b grant=%b ack=%b wen=%b din=%h",
               cyc, req, full, rst, grant, ack, wen_a, din_a);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] eg, input logic [3:0] ea,
                            input logic ew, input logic [7:0] ed);
    check_eq({tag, "_grant"}, 32'(grant), 32'(eg));
    check_eq({tag, "_ack"},   32'(ack),   32'(ea));
    check_eq({tag, "_wen"},   32'(wen_a), 32'(ew));
    check_eq({tag, "_din"},   32'(din_a), 32'(ed));
  endtask

  task automatic do_reset();
    run_cycle(4'b0000, 1'b0, 1'b1);
    run_cycle(4'b0000, 1'b0, 1'b0);
    expect_out("reset", 4'b0000, 4'b0000, 1'b0, 8'h00);
  endtask

  logic [3:0] prev_grant;
  logic [3:0] prev_req;
  int beats;
  int waits [4];

  initial begin
    // Reset state.
    do_reset();

    // Single requester, long burst: acks in 1-4, 6-9, 11.
    for (int c = 0; c < 12; c++) begin
      run_cycle(4'b0001, 1'b0, 1'b0);
      if (c == 0 || c == 5 || c == 10)
        expect_out("single_idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
      else
        expect_out("single_beat", 4'b0001, 4'b0001, 1'b1, din_of(0));
    end
    run_cycle(4'b0000, 1'b0, 1'b0);
    expect_out("single_drop", 4'b0001, 4'b0000, 1'b0, din_of(0));

    // Round robin with everyone requesting: grants 0,1,2,3,0.
    do_reset();
    for (int c = 0; c < 25; c++) begin
      run_cycle(4'b1111, 1'b0, 1'b0);
      if (c % 5 == 0) begin
        expect_out("rr_idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
      end else begin
        int g;
        g = (c / 5) % 4;
        expect_out("rr_beat", 4'(1 << g), 4'(1 << g), 1'b1, din_of(g));
      end
    end

    // Full stall on requester 2.
    do_reset();
    run_cycle(4'b0100, 1'b0, 1'b0);
    expect_out("stall_arb", 4'b0000, 4'b0000, 1'b0, 8'h00);
    for (int c = 0; c < 2; c++) begin
      run_cycle(4'b0100, 1'b0, 1'b0);
      expect_out("stall_pre", 4'b0100, 4'b0100, 1'b1, din_of(2));
    end
    for (int c = 0; c < 5; c++) begin
      run_cycle(4'b0100, 1'b1, 1'b0);
      expect_out("stall_hold", 4'b0100, 4'b0000, 1'b0, din_of(2));
    end
    for (int c = 0; c < 2; c++) begin
      run_cycle(4'b0100, 1'b0, 1'b0);
      expect_out("stall_post", 4'b0100, 4'b0100, 1'b1, din_of(2));
    end
    run_cycle(4'b1111, 1'b0, 1'b0);
    expect_out("stall_rel", 4'b0000, 4'b0000, 1'b0, 8'h00);
    run_cycle(4'b1111, 1'b0, 1'b0);
    expect_out("stall_ptr3", 4'b1000, 4'b1000, 1'b1, din_of(3));

    // Early drop by requester 1; requester 3 waits, then wins from ptr=2.
    do_reset();
    run_cycle(4'b0010, 1'b0, 1'b0);
    expect_out("drop_arb", 4'b0000, 4'b0000, 1'b0, 8'h00);
    run_cycle(4'b1010, 1'b0, 1'b0);
    expect_out("drop_beat", 4'b0010, 4'b0010, 1'b1, din_of(1));
    run_cycle(4'b1000, 1'b0, 1'b0);
    expect_out("drop_cycle", 4'b0010, 4'b0000, 1'b0, din_of(1));
    run_cycle(4'b1010, 1'b0, 1'b0);
    expect_out("drop_idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
    run_cycle(4'b1010, 1'b0, 1'b0);
    expect_out("drop_next3", 4'b1000, 4'b1000, 1'b1, din_of(3));

    // Reset during the second beat of a burst.
    do_reset();
    run_cycle(4'b0001, 1'b0, 1'b0);
    run_cycle(4'b0001, 1'b0, 1'b0);
    expect_out("rstmid_beat1", 4'b0001, 4'b0001, 1'b1, din_of(0));
    run_cycle(4'b0001, 1'b0, 1'b1);
    check_eq("rstmid_wen", 32'(wen_a), 32'd0);
    check_eq("rstmid_ack", 32'(ack), 32'd0);
    run_cycle(4'b0010, 1'b0, 1'b0);
    expect_out("rstmid_after", 4'b0000, 4'b0000, 1'b0, 8'h00);
    run_cycle(4'b0010, 1'b0, 1'b0);
    expect_out("rstmid_regrant", 4'b0010, 4'b0010, 1'b1, din_of(1));

    // Random invariant run.
    do_reset();
    quiet      = 1'b1;
    prev_grant = '0;
    prev_req   = '0;
    beats      = 0;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    begin
      logic [3:0] r;
      r = '0;
      for (int c = 0; c < 10000; c++) begin
        for (int i = 0; i < 4; i++)
          if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
        run_cycle(r, ($urandom_range(0, 3) == 0), 1'b0);
        check_eq("inv_onehot", 32'($onehot0(ack)), 32'd1);
        check_eq("inv_wen_full", 32'(wen_a & full), 32'd0);
        check_eq("inv_ack_wen", 32'(|ack), 32'(wen_a));
        if (wen_a) check_eq("inv_ack_grant", 32'(ack), 32'(grant));
        if (grant != prev_grant) beats = 0;
        if (|ack) beats++;
        check_eq("inv_burst_len", 32'(beats <= 4), 32'd1);
        if (prev_grant == 4'b0000 && grant != 4'b0000) begin
          for (int i = 0; i < 4; i++) begin
            if (grant[i]) waits[i] = 0;
            else if (prev_req[i]) waits[i]++;
            check_eq("inv_fair", 32'(waits[i] <= 3), 32'd1);
          end
        end
        for (int i = 0; i < 4; i++)
          if (!req[i]) waits[i] = 0;
        prev_grant = grant;
        prev_req   = req;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
